// File: rtl/rriot_timer.sv
// ---------------------------------------------------------------------------
// rriot_timer
//
// Programmable interval timer of the RRIOT. It shares chip-select, write
// strobe, address and data with the I/O port block. The timer does an 8-bit
// down-count through a prescaler with a divisor of 1, 8, 64 or 1024, sets a
// flag on underflow, and drives an active-low interrupt that the top level
// routes onto PB7.
//
// Optional feature (macro TIMER_IRQ_EN):
//   defined   : an irq_en register is loaded from A[3] on writes and timer
//               reads, and irq_n = ~(flag & irq_en).
//   undefined : there is no irq_en register, A[3] is ignored and irq_n is
//               tied to 1. The flag behaves the same in both builds and can
//               be read back with a flag read.
//
// Ports:
//   clk     in   1  system clock
//   rst_n   in   1  asynchronous active-low reset
//   enable  in   1  timer chip-select, already decoded; qualifies every access
//   we_n    in   1  0 = write, 1 = read (sampled only when enable=1)
//   A       in   4  write: A[1:0] divisor select (1/8/64/1024)
//                   read : A[0] 0 = timer count, 1 = flag
//                   A[3] IRQ enable; A[2] unused
//   DI      in   8  write data (new count)
//   DO      out  8  registered read data
//   OE      out  1  registered read-data valid / bus drive enable
//   irq_n   out  1  active-low interrupt (combinational)
//
// Bus protocol: an access is taken on the rising clock edge where
// enable=1. Read data appears on DO, with OE high, for the one cycle that
// follows the access edge. OE drops after any edge where enable=0 or a write
// occurs. DO keeps its last value while OE is low.
// ---------------------------------------------------------------------------
module rriot_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       we_n,
   input  logic [3:0] A,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   output logic       OE,
   output logic       irq_n
);

   logic [7:0] count;
   logic [9:0] pre;       // prescale counter, counts 0 .. divisor-1
   logic [1:0] div_sel;   // 00:1 01:8 10:64 11:1024
   logic       flag;
   logic [9:0] pre_last;  // divisor-1 for the current selection
   logic       tick;
   logic       underflow;
   logic       wr;
   logic       rd_timer;
   logic       rd_flag;

   // Access decode
   assign wr       = enable & ~we_n;
   assign rd_timer = enable &  we_n & ~A[0];
   assign rd_flag  = enable &  we_n &  A[0];

   always_comb begin
      pre_last = 10'd0;
      case (div_sel)
         2'b00:   pre_last = 10'd0;
         2'b01:   pre_last = 10'd7;
         2'b10:   pre_last = 10'd63;
         default: pre_last = 10'd1023;
      endcase
   end

   assign tick      = (pre == pre_last);
   assign underflow = tick & (count == 8'h00);

   // Prescaler. A write restarts it from 0, so the first tick comes exactly
   // one divisor period after the write edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= 10'd0;
      end else if (wr || tick) begin
         pre <= 10'd0;
      end else begin
         pre <= pre + 10'd1;
      end
   end

   // Count and divisor. A write takes priority over a tick in the same
   // cycle. On underflow the count wraps from 00 to FF, and the divisor
   // drops to 1 until the next write so that the count runs every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= 8'hFF;
         div_sel <= 2'b00;
      end else if (wr) begin
         count   <= DI;
         div_sel <= A[1:0];
      end else if (tick) begin
         count <= count - 8'd1;
         if (underflow) begin
            div_sel <= 2'b00;
         end
      end
   end

   // Underflow flag. A write clears it. A timer read also clears it, but an
   // underflow in the same cycle wins and sets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag <= 1'b0;
      end else if (wr) begin
         flag <= 1'b0;
      end else if (underflow) begin
         flag <= 1'b1;
      end else if (rd_timer) begin
         flag <= 1'b0;
      end
   end

   // Read data path. A timer read returns the count as it was before any
   // decrement in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DO <= 8'h00;
         OE <= 1'b0;
      end else begin
         OE <= rd_timer | rd_flag;
         if (rd_timer) begin
            DO <= count;
         end else if (rd_flag) begin
            DO <= {flag, 7'b0};
         end
      end
   end

`ifdef TIMER_IRQ_EN
   logic irq_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
      end else if (wr || rd_timer) begin
         irq_en <= A[3];
      end
   end

   assign irq_n = ~(flag & irq_en);

   logic unused_bits;
   assign unused_bits = A[2];
`else
   assign irq_n = 1'b1;

   logic unused_bits;
   assign unused_bits = ^A[3:2];
`endif

endmodule

// File: tb/tb_rriot_timer.sv
// ---------------------------------------------------------------------------
// tb_rriot_timer
//
// Testbench for rriot_timer. It runs a directed sequence taken from the
// timer's intended use, then randomized bus traffic. Both are checked every
// cycle against a reference model. The model tracks the number of cycles
// left until the next tick and the divisor as a plain integer.
// ---------------------------------------------------------------------------
module tb_rriot_timer;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       we_n;
   logic [3:0] A;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       OE;
   logic       irq_n;

   rriot_timer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .we_n   (we_n),
      .A      (A),
      .DI     (DI),
      .DO     (DO),
      .OE     (OE),
      .irq_n  (irq_n)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   int         n_total;
   int         n_bad;
   int         m_count;
   int         m_div;
   int         m_rem;     // cycles until the next tick
   bit         m_flag;
   bit         m_irq_en;
   logic [7:0] m_do;
   bit         m_oe;

   function automatic int div_of(input logic [1:0] s);
      case (s)
         2'd0:    return 1;
         2'd1:    return 8;
         2'd2:    return 64;
         default: return 1024;
      endcase
   endfunction

   task automatic model_reset();
      m_count  = 255;
      m_div    = 1;
      m_rem    = 1;
      m_flag   = 0;
      m_irq_en = 0;
      m_do     = 8'h00;
      m_oe     = 0;
   endtask

   // Computes the model state after one clock edge from the inputs applied
   // before that edge.
   task automatic model_step(input bit en, input bit wen, input logic [3:0] a,
                             input logic [7:0] di);
      bit tick;
      tick = (m_rem == 1);
      if (en && !wen) begin
         m_count  = di;
         m_div    = div_of(a[1:0]);
         m_rem    = m_div;
         m_flag   = 0;
         m_irq_en = a[3];
         m_oe     = 0;
      end else begin
         m_oe = en;
         if (en) begin
            if (!a[0]) begin
               m_do     = m_count[7:0];
               m_flag   = 0;        // an underflow below sets it again
               m_irq_en = a[3];
            end else begin
               m_do = {m_flag, 7'b0};
            end
         end
         if (tick) begin
            if (m_count == 0) begin
               m_count = 255;
               m_flag  = 1;
               m_div   = 1;
            end else begin
               m_count = m_count - 1;
            end
            m_rem = m_div;
         end else begin
            m_rem = m_rem - 1;
         end
      end
   endtask

   function automatic bit exp_irq_n();
`ifdef TIMER_IRQ_EN
      return !(m_flag && m_irq_en);
`else
      return 1'b1;
`endif
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, ".do"},  {8'h00, DO},    {8'h00, m_do});
      check_eq({tag, ".oe"},  {15'h0, OE},    {15'h0, m_oe});
      check_eq({tag, ".irq"}, {15'h0, irq_n}, {15'h0, exp_irq_n()});
   endtask

   // ---------------- driver tasks ----------------
   // Each task is entered at a falling edge and returns at the next falling
   // edge. It checks the outputs #1 after the rising edge.
   task automatic cyc(input string tag, input bit en, input bit wen,
                      input logic [3:0] a, input logic [7:0] di);
      enable = en;
      we_n   = wen;
      A      = a;
      DI     = di;
      model_step(en, wen, a, di);
      @(posedge clk);
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b1, 4'h0, 8'h00);
   endtask

   task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] di);
      cyc(tag, 1'b1, 1'b0, a, di);
   endtask

   task automatic do_read(input string tag, input logic [3:0] a);
      cyc(tag, 1'b1, 1'b1, a, 8'h00);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      enable  = 1'b0;
      we_n    = 1'b1;
      A       = 4'h0;
      DI      = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;

      idle("post_reset", 2);
      do_read("flag_after_reset", 4'b0001);
      check_eq("flag_after_reset.val", {8'h00, DO}, 16'h0000);

      // Divisor 1 with the IRQ enabled: underflow 6 cycles after the write.
      do_write("wr05", 4'b1000, 8'h05);
      idle("run05", 4);
      do_read("flag05_early", 4'b1001);
      check_eq("flag05_early.val", {8'h00, DO}, 16'h0000);
      idle("run05b", 2);
      do_read("flag05_set", 4'b1001);
      check_eq("flag05_set.val", {8'h00, DO}, 16'h0080);
      do_read("tmr_after_uf", 4'b1000);
      do_read("tmr_after_uf2", 4'b0000);
      idle("irq_clear", 2);

      // Divisor 8 with the IRQ disabled.
      do_write("wr02", 4'b0001, 8'h02);
      idle("run02", 5);
      do_read("tmr02_a", 4'b0000);
      do_read("tmr02_b", 4'b0000);
      do_read("tmr02_c", 4'b0000);
      idle("run02b", 18);
      do_read("flag02", 4'b0001);

      // Write in the same cycle as a tick with an underflow pending.
      do_write("wr00", 4'b1000, 8'h00);
      do_write("wr0a_tick", 4'b1000, 8'h0A);
      do_read("tmr0a", 4'b1000);
      check_eq("tmr0a.val", {8'h00, DO}, 16'h000A);
      do_read("flag0a", 4'b1001);

      // Timer read in the same cycle as an underflow: the flag still sets.
      do_write("wr01", 4'b1000, 8'h01);
      idle("run01", 1);
      do_read("tmr_at_uf", 4'b1000);
      do_read("flag_at_uf", 4'b1001);

      // Asynchronous reset mid-count with divisor 1024.
      do_write("wr_1024", 4'b1011, 8'h03);
      idle("run1024", 300);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      #1 rst_n = 1'b1;
      @(negedge clk);
      do_read("flag_after_rst", 4'b0001);
      do_write("wr_1024b", 4'b0011, 8'h00);
      idle("run1024b", 1030);
      do_read("flag_1024b", 4'b0001);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            do_write("rnd_wr", 4'($urandom), d);
         end else if (r < 18) begin
            do_read("rnd_rd", 4'($urandom));
         end else begin
            cyc("rnd_idle", 1'b0, $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
